// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and default width for the serial subtractor
package serial_sub_pkg;

  // Default operand/result width in bits (legal range 2..64)
  localparam int DEFAULT_WIDTH = 8;

  // Controller states: wait for a request, shift bits through, present results
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor, a - b - bin
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Borrow out when b (plus incoming borrow) exceeds a for this bit
  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b with borrow, overflow and zero flags
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr,
  output logic             ovf,
  output logic             zero
);

  // Counter only needs to reach WIDTH, never beyond
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             bin;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH-1:0] sr_next;

  full_subtractor u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (bin),
    .diff (bit_d),
    .bout (bit_bout)
  );

  // LSB-first results enter at the top, so after WIDTH shifts bit 0 lands at index 0
  assign sr_next = {bit_d, sr[WIDTH-1:1]};

  // Controller and datapath: capture, shift WIDTH times, publish flags on the final shift
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      bin   <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      borr  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            sr    <= '0;
            bin   <= 1'b0;
            cnt   <= '0;
            // Sign bits are kept aside since the operand registers shift them away
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          sr  <= sr_next;
          bin <= bit_bout;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= sr_next;
            borr  <= bit_bout;
            ovf   <= (a_msb != b_msb) && (bit_d != a_msb);
            zero  <= (sr_next == '0);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borr;
  logic       ovf;
  logic       zero;

  int n_assert = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borr  (borr),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    int cyc;
    int bcnt;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    bcnt = 0;
    while (!done && cyc < 30) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 9);
    chk({tag, "_busy_cycles"}, bcnt, 8);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borr"}, borr, eb);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int cyc;
    int gap;
    int cnt_busy;
    int cnt_done;

    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 8'h00);
    chk("reset_borr", borr, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_zero", zero, 0);
    rst = 1'b0;

    run_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    run_op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op("sub_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);

    // Reset during the fourth SHIFT cycle aborts the operation
    @(negedge clk);
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 8'h00);
    chk("midrst_borr", borr, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_zero", zero, 0);
    rst = 1'b0;
    cnt_done = 0;
    cnt_busy = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    chk("midrst_no_done", cnt_done, 0);
    chk("midrst_no_busy", cnt_busy, 0);

    run_op("sub_ff_00", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("sub_5a_5a", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1);

    // start held high: results hold during SHIFT, one done every 10 cycles
    @(negedge clk);
    a = 8'h20;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    chk("held_busy", busy, 1);
    chk("held_diff_hold", diff, 8'h00);
    chk("held_zero_hold", zero, 1);
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_latency", cyc, 9);
    chk("held_diff", diff, 8'h1F);
    chk("held_zero", zero, 0);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!done && gap < 30);
    start = 1'b0;
    chk("held_done_period", gap, 10);
    chk("held_diff2", diff, 8'h1F);
    @(negedge clk);
    chk("held_done_pulse", done, 0);

    // Operands change and start re-pulses mid-SHIFT; captured values win
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'hFF;
    b = 8'hFF;
    cyc = 1;
    @(negedge clk);
    cyc++;
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("chg_latency", cyc, 9);
    chk("chg_diff", diff, 8'h0F);
    chk("chg_borr", borr, 0);
    chk("chg_ovf", ovf, 0);
    chk("chg_zero", zero, 0);
    cnt_done = 0;
    cnt_busy = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    chk("chg_no_queued_done", cnt_done, 0);
    chk("chg_no_queued_busy", cnt_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request; sampled only in IDLE.
REQ-006 Port: a  input  WIDTH  minuend; captured on the accepting edge.
REQ-007 Port: b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-008 Port: busy  output  1  high while bits are being processed.
REQ-009 Port: done  output  1  one-cycle pulse; results valid.
REQ-010 Port: diff  output  WIDTH  registered a-b modulo 2^WIDTH.
REQ-011 Port: borr  output  1  final borrow; 1 iff a<b unsigned.
REQ-012 Port: ovf  output  1  signed (two's-complement) overflow of a-b.
REQ-013 Port: zero  output  1  high iff diff==0.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-015 In IDLE with start=1, the edge SHALL load a and b into internal shift registers, clear the borrow flop, clear the bit counter, and enter SHIFT.
REQ-016 Each SHIFT edge SHALL process the current LSBs: d = a0^b0^bin; bout = (~a0&b0) | (~(a0^b0)&bin); d shifts into the partial-result MSB; bout is stored as the next bin.
REQ-017 After exactly WIDTH SHIFT edges, the FSM SHALL enter DONE, and diff, borr, ovf and zero SHALL update on that same edge.
REQ-018 Latency SHALL be WIDTH+1 edges from the accepting edge to done high, i.e. 9 edges for WIDTH=8.
REQ-019 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE.
REQ-020 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-021 ovf SHALL equal (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the captured operands.
REQ-022 start in SHIFT or DONE SHALL be ignored, with no queuing.
REQ-023 A changing a or b after the accepting edge SHALL NOT affect the result.
REQ-024 diff, borr, ovf and zero SHALL hold their last values until the next DONE; they SHALL NOT change during SHIFT.
REQ-025 The counter SHALL be $clog2(WIDTH+1) bits wide, and processing SHALL stop at WIDTH with no wrap past it.

Reset
REQ-026 rst=1 on any edge SHALL force IDLE and clear busy, done, diff, borr, ovf, zero, the counter and the borrow flop to 0.
REQ-027 rst SHALL take priority over start and over an in-progress operation; a reset mid-SHIFT SHALL abort with no done pulse.
REQ-028 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-029 Package serial_sub_pkg SHALL hold the state typedef/encoding (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-030 The per-bit logic SHALL be a combinational sub-module full_subtractor (a, b, bin -> diff, bout), instantiated once.
REQ-031 The datapath SHALL consist of the operand shift registers, partial-result shift register, borrow flop, counter, output registers and the FSM; no other sub-modules.

Verification (WIDTH=8)
REQ-032 a=0x05, b=0x03, start one cycle -> done 9 edges later; diff=0x02, borr=0, ovf=0, zero=0; busy high for 8 cycles.
REQ-033 a=0x03, b=0x05 -> diff=0xFE, borr=1, ovf=0, zero=0.
REQ-034 a=0x80, b=0x01 -> diff=0x7F, borr=0, ovf=1; and a=0x7F, b=0xFF -> diff=0x80, borr=1, ovf=1.
REQ-035 a=0x5A, b=0x5A -> diff=0x00, zero=1, borr=0; then start held high continuously -> a new operation is accepted only from IDLE, with one done per 10 cycles.
REQ-036 start a=0x10, b=0x01; change a/b on the next cycle; pulse start again mid-SHIFT -> diff=0x0F from the captured values, and the second start is ignored.
REQ-037 rst asserted at SHIFT cycle 4 -> all outputs 0 on the next edge with no done; a subsequent a=0xFF, b=0x00 gives diff=0xFF.
